// File: rtl/sys_arr_row_sequencer_if.sv
// sys_arr_row_sequencer_if: command, row-stream, array-write and output-tracking signals of the row sequencer.
// SYS_ARR_SEQ_PERF_EN adds the perf counter outputs.
interface sys_arr_row_sequencer_if #(parameter int N = 4, parameter int DW = 16, parameter int SETW = 8);
  localparam int IW = $clog2(N);
  logic cmd_valid, cmd_ready, cmd_weights;
  logic [SETW-1:0] cmd_nsets;
  logic row_valid, row_ready;
  logic [N*DW-1:0] row_data, row_ps;
  logic drained, fifo_has_space;
  logic weight_en, input_en, partial_en;
  logic [IW-1:0] row_in_en, row_ps_en, row_out;
  logic [N*DW-1:0] array_in, array_in_partials;
  logic out_en, job_done, err_order;
`ifdef SYS_ARR_SEQ_PERF_EN
  logic [31:0] perf_busy, perf_stall_src, perf_stall_arr;
`endif
  modport master (
    input cmd_valid, cmd_weights, cmd_nsets, row_valid, row_data, row_ps, drained, fifo_has_space, out_en, row_out,
    output cmd_ready, row_ready, weight_en, input_en, partial_en, row_in_en, row_ps_en, array_in, array_in_partials,
    output job_done, err_order
`ifdef SYS_ARR_SEQ_PERF_EN
    , output perf_busy, perf_stall_src, perf_stall_arr
`endif
  );
  modport slave (
    output cmd_valid, cmd_weights, cmd_nsets, row_valid, row_data, row_ps, drained, fifo_has_space, out_en, row_out,
    input cmd_ready, row_ready, weight_en, input_en, partial_en, row_in_en, row_ps_en, array_in, array_in_partials,
    input job_done, err_order
`ifdef SYS_ARR_SEQ_PERF_EN
    , input perf_busy, perf_stall_src, perf_stall_arr
`endif
  );
endinterface

// File: rtl/sys_arr_row_sequencer.sv
// sys_arr_row_sequencer: streams weight/input rows of a job into the systolic array and tracks returned rows.
// SYS_ARR_SEQ_PERF_EN enables the saturating busy/stall perf counters.
module sys_arr_row_sequencer #(
  parameter int N = 4,
  parameter int DW = 16,
  parameter int ROW_GAP = 1,
  parameter int SETW = 8
) (
  input logic clk,
  input logic RST,
  sys_arr_row_sequencer_if.master bus
);
  localparam int IW = $clog2(N);
  localparam int CW = SETW + IW;
  localparam int GW = ROW_GAP > 0 ? $clog2(ROW_GAP + 1) : 1;
  typedef enum logic [2:0] {IDLE, WAIT_DRAIN, LOAD_W, WAIT_SPACE, LOAD_IN, GAP, WAIT_OUT} state_t;
  state_t state, state_n;
  logic [IW-1:0] r;
  logic [SETW-1:0] nsets_q, set_cnt;
  logic [GW-1:0] gap_cnt;
  logic [CW-1:0] out_cnt, out_nxt;
  logic accept, hs, row_last, set_last, gap_done, set_adv;
  always_comb begin
    accept = bus.cmd_valid && state == IDLE;
    bus.cmd_ready = state == IDLE;
    bus.row_ready = state == LOAD_W || state == LOAD_IN;
    hs = bus.row_valid && bus.row_ready;
    row_last = r == IW'(N - 1);
    set_last = set_cnt == nsets_q - 1'b1;
    gap_done = gap_cnt == GW'(ROW_GAP - 1);
    out_nxt = out_cnt + CW'(bus.out_en);
    bus.job_done = state == WAIT_OUT && out_nxt == CW'(nsets_q) * CW'(N);
    state_n = state;
    case (state)
      IDLE:       state_n = accept ? (bus.cmd_weights ? WAIT_DRAIN : WAIT_SPACE) : IDLE;
      WAIT_DRAIN: state_n = bus.drained ? LOAD_W : WAIT_DRAIN;
      LOAD_W:     state_n = hs && row_last ? WAIT_SPACE : LOAD_W;
      WAIT_SPACE: state_n = bus.fifo_has_space ? LOAD_IN : WAIT_SPACE;
      LOAD_IN:    state_n = !hs ? LOAD_IN : ROW_GAP > 0 ? GAP : !row_last ? LOAD_IN : set_last ? WAIT_OUT : WAIT_SPACE;
      // r has already wrapped to 0 when the gap follows the last row of a matrix
      GAP:        state_n = !gap_done ? GAP : r != '0 ? LOAD_IN : set_last ? WAIT_OUT : WAIT_SPACE;
      WAIT_OUT:   state_n = bus.job_done ? IDLE : WAIT_OUT;
      default:    state_n = IDLE;
    endcase
    set_adv = state_n == WAIT_SPACE && (state == LOAD_IN || state == GAP);
  end
  always_ff @(posedge clk or posedge RST)
    if (RST) begin
      state <= IDLE;
      r <= '0;
      nsets_q <= '0;
      set_cnt <= '0;
      gap_cnt <= '0;
      out_cnt <= '0;
      bus.err_order <= 1'b0;
      bus.weight_en <= 1'b0;
      bus.input_en <= 1'b0;
      bus.partial_en <= 1'b0;
      bus.row_in_en <= '0;
      bus.row_ps_en <= '0;
      bus.array_in <= '0;
      bus.array_in_partials <= '0;
    end else begin
      state <= state_n;
      if (hs) r <= row_last ? '0 : r + 1'b1;
      gap_cnt <= state == GAP ? gap_cnt + 1'b1 : '0;
      if (accept) nsets_q <= bus.cmd_nsets == '0 ? SETW'(1) : bus.cmd_nsets;
      set_cnt <= accept ? '0 : set_adv ? set_cnt + 1'b1 : set_cnt;
      out_cnt <= accept ? '0 : out_nxt;
      bus.err_order <= !accept && (bus.err_order || (bus.out_en && bus.row_out != IW'(out_cnt % CW'(N))));
      bus.weight_en <= hs && state == LOAD_W;
      bus.input_en <= hs && state == LOAD_IN;
      bus.partial_en <= hs && state == LOAD_IN;
      bus.row_in_en <= hs ? r : '0;
      bus.row_ps_en <= hs && state == LOAD_IN ? r : '0;
      bus.array_in <= hs ? bus.row_data : '0;
      bus.array_in_partials <= hs && state == LOAD_IN ? bus.row_ps : '0;
    end
`ifdef SYS_ARR_SEQ_PERF_EN
  always_ff @(posedge clk or posedge RST)
    if (RST) begin
      bus.perf_busy <= '0;
      bus.perf_stall_src <= '0;
      bus.perf_stall_arr <= '0;
    end else begin
      bus.perf_busy <= accept ? '0 : bus.perf_busy + 32'(state != IDLE && !(&bus.perf_busy));
      bus.perf_stall_src <= accept ? '0 : bus.perf_stall_src + 32'(bus.row_ready && !bus.row_valid && !(&bus.perf_stall_src));
      bus.perf_stall_arr <= accept ? '0 :
        bus.perf_stall_arr + 32'((state == WAIT_DRAIN || state == WAIT_SPACE) && !(&bus.perf_stall_arr));
    end
`endif
endmodule

// File: tb/tb_sys_arr_row_sequencer.sv
// tb_sys_arr_row_sequencer: scoreboard bench; drivers queue expected array writes, a negedge monitor checks them.
module tb_sys_arr_row_sequencer;
  localparam int N = 4, DW = 16, ROW_GAP = 1, SETW = 8, W = N * DW;
  logic tb_clk = 1'b0;
  logic rst = 1'b0;
  always #5 tb_clk = ~tb_clk;
  sys_arr_row_sequencer_if #(.N(N), .DW(DW), .SETW(SETW)) bus();
  sys_arr_row_sequencer #(.N(N), .DW(DW), .ROW_GAP(ROW_GAP), .SETW(SETW)) dut (.clk(tb_clk), .RST(rst), .bus(bus));
  typedef struct {logic w; logic [1:0] idx; logic [W-1:0] d; int sp;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, exp_done = 0, cyc = 0, last_en = 0;
  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask
  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask
  // monitor: every array write must match the head of the scoreboard, idle cycles must be all zero
  always @(negedge tb_clk) begin
    exp_t e;
    cyc++;
    if (bus.weight_en || bus.input_en) begin
      chk("row_expected", q.size() > 0, 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("row", {bus.weight_en, bus.input_en, bus.partial_en, bus.row_in_en, bus.row_ps_en, bus.array_in, bus.array_in_partials},
            {e.w, !e.w, !e.w, e.idx, (e.w ? 2'd0 : e.idx), e.d, (e.w ? W'(0) : ~e.d)});
        if (e.sp > 0) chk("row_spacing", cyc - last_en, e.sp);
      end
      last_en = cyc;
    end else chk("idle_outputs", {bus.partial_en, bus.row_in_en, bus.row_ps_en, bus.array_in, bus.array_in_partials}, 0);
    if (bus.job_done) begin
      chk("job_done_expected", exp_done > 0, 1);
      if (exp_done > 0) exp_done--;
    end
  end
  task automatic cmd(input bit w, input int ns);
    int t;
    t = 0;
    while (!bus.cmd_ready && t < 200) begin tick(); t++; end
    chk("cmd_ready", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_weights = w;
    bus.cmd_nsets = SETW'(ns);
    tick();
    bus.cmd_valid = 1'b0;
  endtask
  task automatic feed(input int nw, input int ni, input int vgap, input int base);
    for (int k = 0; k < nw + ni; k++) begin
      bit w;
      int i, t, sp;
      logic [W-1:0] d;
      w = k < nw;
      i = w ? k : (k - nw) % N;
      t = 0;
      for (int j = 0; j < N; j++) d[j*DW +: DW] = DW'(base + k * N + j);
      if (vgap > 0) begin bus.row_valid = 1'b0; repeat (vgap) tick(); end
      bus.row_valid = 1'b1;
      bus.row_data = d;
      bus.row_ps = ~d;
      @(negedge tb_clk);
      while (!bus.row_ready && t < 300) begin @(negedge tb_clk); t++; end
      chk("row_handshake", bus.row_ready, 1);
      sp = i == 0 ? 0 : vgap > 0 ? vgap + 1 : w ? 1 : ROW_GAP + 1;
      q.push_back('{w, 2'(i), d, sp});
      tick();
    end
    bus.row_valid = 1'b0;
  endtask
  task automatic outs(input int n, input bit swap);
    for (int k = 0; k < n; k++) begin
      bus.out_en = 1'b1;
      bus.row_out = 2'(k % N);
      if (swap && (k == 1 || k == 2)) bus.row_out = k == 1 ? 2'd2 : 2'd1;
      if (k == n - 1) exp_done++;
      tick();
      if (swap) chk("err_order_seq", bus.err_order, k >= 1);
    end
    bus.out_en = 1'b0;
    chk("job_done_count", exp_done, 0);
  endtask
  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_weights = 1'b0; bus.cmd_nsets = '0;
    bus.row_valid = 1'b0; bus.row_data = '0; bus.row_ps = '0;
    bus.drained = 1'b0; bus.fifo_has_space = 1'b0; bus.out_en = 1'b0; bus.row_out = '0;
    #2 rst = 1'b1;
    repeat (2) tick();
    chk("reset_cmd_ready", bus.cmd_ready, 1);
    chk("reset_quiet", {bus.row_ready, bus.job_done, bus.err_order, bus.weight_en, bus.input_en}, 0);
    rst = 1'b0;
    tick();
    bus.drained = 1'b1;
    bus.fifo_has_space = 1'b1;
    cmd(1, 1);
    feed(4, 4, 0, 'h100);
    repeat (4) tick();
    outs(4, 0);
    chk("err_order_clean", bus.err_order, 0);
    bus.drained = 1'b0;
    cmd(1, 1);
    bus.row_valid = 1'b1;
    bus.row_data = '1;
    repeat (10) begin @(negedge tb_clk); chk("drain_wait_row_ready", bus.row_ready, 0); end
    tick();
    bus.drained = 1'b1;
    feed(4, 4, 0, 'h200);
    repeat (4) tick();
    outs(4, 0);
    cmd(0, 3);
    for (int s = 0; s < 3; s++) begin
      if (s > 0) begin
        bus.fifo_has_space = 1'b0;
        repeat (6) begin @(negedge tb_clk); chk("space_wait_row_ready", bus.row_ready, 0); end
        tick();
        bus.fifo_has_space = 1'b1;
      end
      feed(0, 4, 0, 'h300 + s * 'h40);
    end
    repeat (4) tick();
    outs(12, 0);
    cmd(0, 1);
    feed(0, 4, 0, 'h400);
    repeat (4) tick();
    outs(4, 1);
    cmd(0, 0);
    chk("err_cleared_on_accept", bus.err_order, 0);
    feed(0, 4, 3, 'h500);
    repeat (4) tick();
    outs(4, 0);
    cmd(0, 1);
    feed(0, 2, 0, 'h600);
    bus.out_en = 1'b1;
    bus.row_out = 2'd2;
    tick();
    bus.out_en = 1'b0;
    chk("err_order_set", bus.err_order, 1);
    tick();
    chk("mid_load_in_row_ready", bus.row_ready, 1);
    bus.row_valid = 1'b1;
    #2 rst = 1'b1;
    @(negedge tb_clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_enables", {bus.weight_en, bus.input_en, bus.partial_en, bus.row_ready}, 0);
    chk("rst_err_order", bus.err_order, 0);
    chk("rst_no_pending_rows", q.size(), 0);
    tick();
    bus.row_valid = 1'b0;
    rst = 1'b0;
    repeat (5) tick();
    chk("final_pending_rows", q.size(), 0);
    chk("final_pending_done", exp_done, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
